// File: rtl/uart_rx_ram_writer_if.sv
// RAM write-port bundle driven by the UART receiver: word address, word data, 1-cycle strobe.
interface uart_rx_ram_writer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wren;

    modport master (output waddr, output wdata, output wren);
    modport slave  (input  waddr, input  wdata, input  wren);
endinterface

// File: rtl/uart_rx_ram_writer.sv
// 8N1 UART receiver packing bytes little-endian into RAM words with auto-incrementing address.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits (adds parity_err).
module uart_rx_ram_writer #(
    parameter int CLOCK_RATE = 24000000,
    parameter int BAUD_RATE  = 1200,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_rx,
    uart_rx_ram_writer_if.master ram,
    output logic [7:0]           rx_byte,
    output logic                 rx_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 wrapped
);
    localparam int CLKS_PER_BIT   = CLOCK_RATE / BAUD_RATE;
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int TW             = $clog2(CLKS_PER_BIT);
    localparam int KW             = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [KW-1:0] LAST = KW'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic parity_err_q;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t                state_q;
    logic                  sync1_q, sync2_q, prev_q;
    logic [TW-1:0]         timer_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic                  par_bad_q, stop_bad_q;
    logic [KW-1:0]         k_q;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wren_q;
    logic [7:0]            rx_byte_q;
    logic                  rx_valid_q, frame_err_q, wrapped_q;

    // Partial word with the incoming byte dropped into lane k.
    always_comb begin
        word_d = word_q;
        for (int l = 0; l < BYTES_PER_WORD; l++)
            if (k_q == KW'(l)) word_d[l*8 +: 8] = shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            k_q         <= '0;
            word_q      <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wren_q      <= 1'b0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wrapped_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q    <= ser_rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_valid_q <= 1'b0;
            wren_q     <= 1'b0;
            // Address advances the cycle after the write so the strobe sees the old address.
            if (wren_q) begin
                waddr_q <= waddr_q + 1'b1;
                if (&waddr_q) wrapped_q <= 1'b1;
            end
            if (timer_q != '0) timer_q <= timer_q - 1'b1;
            case (state_q)
                IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= START;
                        timer_q <= HALF;
                    end
                end
                START: begin
                    if (timer_q == '0) begin
                        if (!sync2_q) begin
                            state_q    <= DATA;
                            timer_q    <= FULL;
                            bit_cnt_q  <= '0;
                            par_bad_q  <= 1'b0;
                            stop_bad_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (timer_q == '0) begin
                        shift_q   <= {sync2_q, shift_q[7:1]};
                        timer_q   <= FULL;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer_q == '0) begin
                        if (sync2_q != ^shift_q) begin
                            par_bad_q    <= 1'b1;
                            parity_err_q <= 1'b1;
                        end
                        timer_q <= FULL;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    // After a bad stop bit, hold here until the line returns high.
                    if (stop_bad_q) begin
                        if (sync2_q) state_q <= IDLE;
                    end else if (timer_q == '0) begin
                        if (!sync2_q) begin
                            frame_err_q <= 1'b1;
                            stop_bad_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            if (!par_bad_q) begin
                                rx_byte_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                                if (k_q == LAST) begin
                                    wren_q  <= 1'b1;
                                    wdata_q <= word_d;
                                    k_q     <= '0;
                                end else begin
                                    word_q <= word_d;
                                    k_q    <= k_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram.waddr = waddr_q;
    assign ram.wdata = wdata_q;
    assign ram.wren  = wren_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign wrapped   = wrapped_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_ram_writer.sv
// Bench: two receivers (8-bit and 2-bit address) share one serial line; a byte/word model predicts RAM writes.
module tb_uart_rx_ram_writer;
    localparam int CPB = 16;

    logic clk = 1'b0, rst_n = 1'b0, ser_rx = 1'b1;
    always #5 clk = ~clk;

    uart_rx_ram_writer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ram_a();
    uart_rx_ram_writer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) ram_b();
    logic [7:0] rx_byte_a, rx_byte_b;
    logic       rx_valid_a, rx_valid_b, ferr_a, ferr_b, wrap_a, wrap_b;
`ifdef UART_RX_PARITY_EN
    logic       perr_a, perr_b;
`endif

    uart_rx_ram_writer #(.CLOCK_RATE(160), .BAUD_RATE(10), .ADDR_WIDTH(8), .DATA_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .ser_rx(ser_rx), .ram(ram_a),
        .rx_byte(rx_byte_a), .rx_valid(rx_valid_a), .frame_err(ferr_a),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr_a),
`endif
        .wrapped(wrap_a));

    uart_rx_ram_writer #(.CLOCK_RATE(160), .BAUD_RATE(10), .ADDR_WIDTH(2), .DATA_WIDTH(16)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ser_rx(ser_rx), .ram(ram_b),
        .rx_byte(rx_byte_b), .rx_valid(rx_valid_b), .frame_err(ferr_b),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr_b),
`endif
        .wrapped(wrap_b));

    int checks = 0, failures = 0;

    // Reference model: bytes in, words out at address counters modulo 2^ADDR_WIDTH.
    logic [7:0]  exp_rx[$], act_rx[$];
    logic [23:0] exp_wa[$], act_wa[$];
    logic [17:0] exp_wb[$], act_wb[$];
    int          m_k, m_addr_a, m_addr_b;
    logic [15:0] m_word;
    bit          m_wrap_a, m_wrap_b, m_ferr, m_perr;

    function automatic void model_reset();
        m_k = 0; m_word = '0; m_addr_a = 0; m_addr_b = 0;
        m_wrap_a = 0; m_wrap_b = 0; m_ferr = 0; m_perr = 0;
        exp_rx.delete(); act_rx.delete();
        exp_wa.delete(); act_wa.delete();
        exp_wb.delete(); act_wb.delete();
    endfunction

    function automatic void model_byte(logic [7:0] b, bit stop_ok, bit par_ok);
        if (!stop_ok) m_ferr = 1;
        if (!par_ok)  m_perr = 1;
        if (!stop_ok || !par_ok) return;
        exp_rx.push_back(b);
        m_word[m_k*8 +: 8] = b;
        m_k++;
        if (m_k == 2) begin
            exp_wa.push_back({8'(m_addr_a), m_word});
            exp_wb.push_back({2'(m_addr_b), m_word});
            m_addr_a = (m_addr_a + 1) % 256;
            m_addr_b = (m_addr_b + 1) % 4;
            if (m_addr_a == 0) m_wrap_a = 1;
            if (m_addr_b == 0) m_wrap_b = 1;
            m_k = 0;
        end
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (rx_valid_a) act_rx.push_back(rx_byte_a);
        if (ram_a.wren) act_wa.push_back({ram_a.waddr, ram_a.wdata});
        if (ram_b.wren) act_wb.push_back({ram_b.waddr, ram_b.wdata});
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip);
        bit par_ok;
        par_ok = 1;
        @(negedge clk);
        ser_rx = 1'b0; repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i]; repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        ser_rx = (^b) ^ par_flip; repeat (CPB) @(negedge clk);
        par_ok = !par_flip;
`endif
        ser_rx = stop_bit; repeat (CPB) @(negedge clk);
        ser_rx = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clk);
        model_byte(b, stop_bit, par_ok);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ram_a.waddr, ram_a.wdata, ram_a.wren, rx_byte_a, rx_valid_a, ferr_a, wrap_a} !== '0) begin
            failures++;
            $display("FAIL reset_a: waddr=%h wdata=%h wren=%b rx_byte=%h rx_valid=%b ferr=%b wrap=%b, all required 0",
                     ram_a.waddr, ram_a.wdata, ram_a.wren, rx_byte_a, rx_valid_a, ferr_a, wrap_a);
        end
        checks++;
        if ({ram_b.waddr, ram_b.wdata, ram_b.wren, wrap_b} !== '0) begin
            failures++;
            $display("FAIL reset_b: waddr=%h wdata=%h wren=%b wrap=%b, all required 0",
                     ram_b.waddr, ram_b.wdata, ram_b.wren, wrap_b);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        send_frame(8'h48, 1'b1, 1'b0);
        send_frame(8'h69, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (act_rx.size() != 2 || act_rx[0] !== 8'h48 || act_rx[1] !== 8'h69) begin
            failures++;
            $display("FAIL basic_rx: got %0d bytes first=%h, required 48 69", act_rx.size(), act_rx.size() ? act_rx[0] : 8'hxx);
        end
        checks++;
        if (act_wa.size() != 1 || act_wa[0] !== 24'h006948 || exp_wa[0] !== 24'h006948) begin
            failures++;
            $display("FAIL basic_write: %0d writes first=%h, required one write 006948", act_wa.size(), act_wa.size() ? act_wa[0] : 24'hx);
        end
        checks++;
        if (ram_a.waddr !== 8'(m_addr_a) || ram_a.wren !== 1'b0) begin
            failures++;
            $display("FAIL basic_waddr: waddr=%h wren=%b, required %h and 0", ram_a.waddr, ram_a.wren, 8'(m_addr_a));
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (act_wb.size() != exp_wb.size()) begin
            failures++;
            $display("FAIL wrap_count: %0d writes, required %0d", act_wb.size(), exp_wb.size());
        end
        foreach (exp_wb[i]) begin
            checks++;
            if (i >= act_wb.size() || act_wb[i] !== exp_wb[i]) begin
                failures++;
                $display("FAIL wrap_write%0d: got %h, required %h", i, (i < act_wb.size()) ? act_wb[i] : 18'hx, exp_wb[i]);
            end
        end
        checks++;
        if (act_wb.size() != 5 || act_wb[4] !== {2'd0, 16'h0908}) begin
            failures++;
            $display("FAIL wrap_last: %0d writes, last required addr 0 data 0908", act_wb.size());
        end
        checks++;
        if (wrap_b !== 1'b1 || ram_b.waddr !== 2'd1 || wrap_a !== 1'b0) begin
            failures++;
            $display("FAIL wrap_flags: wrap_b=%b waddr_b=%h wrap_a=%b, required 1 1 0", wrap_b, ram_b.waddr, wrap_a);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        @(negedge clk);
        ser_rx = 1'b0; repeat (4) @(negedge clk);
        ser_rx = 1'b1; repeat (30) @(negedge clk);
        checks++;
        if (act_rx.size() != 0 || act_wa.size() != 0 || ferr_a !== 1'b0) begin
            failures++;
            $display("FAIL glitch: rx=%0d writes=%0d ferr=%b, required 0 0 0", act_rx.size(), act_wa.size(), ferr_a);
        end
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (act_rx.size() != 1 || act_rx[0] !== 8'hA5) begin
            failures++;
            $display("FAIL glitch_recover: got %0d bytes, required one A5", act_rx.size());
        end
    endtask

    task automatic test_frame_err();
        apply_reset();
        send_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (ferr_a !== 1'b1 || ferr_b !== 1'b1) begin
            failures++;
            $display("FAIL ferr_flag: a=%b b=%b, required 1", ferr_a, ferr_b);
        end
        checks++;
        if (act_rx.size() != 2 || act_rx[0] !== 8'h41) begin
            failures++;
            $display("FAIL ferr_rx: %0d bytes, required 41 42 only", act_rx.size());
        end
        checks++;
        if (act_wa.size() != 1 || act_wa[0] !== 24'h004241) begin
            failures++;
            $display("FAIL ferr_write: %0d writes first=%h, required one 004241", act_wa.size(), act_wa.size() ? act_wa[0] : 24'hx);
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        send_frame(8'h11, 1'b1, 1'b0);
        @(negedge clk);
        ser_rx = 1'b0; repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0; ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_a.waddr, ram_a.wdata, ram_a.wren, rx_byte_a, rx_valid_a, ferr_a, wrap_a} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: waddr=%h wdata=%h rx_byte=%h, all required 0", ram_a.waddr, ram_a.wdata, rx_byte_a);
        end
        model_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (act_wa.size() != 1 || act_wa[0] !== 24'h003322) begin
            failures++;
            $display("FAIL midreset_write: %0d writes first=%h, required one 003322", act_wa.size(), act_wa.size() ? act_wa[0] : 24'hx);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 25; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 5) != 0), 1'b0);
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (act_rx.size() != exp_rx.size() || act_wa.size() != exp_wa.size() || act_wb.size() != exp_wb.size()) begin
            failures++;
            $display("FAIL rand_counts: rx %0d/%0d wa %0d/%0d wb %0d/%0d", act_rx.size(), exp_rx.size(),
                     act_wa.size(), exp_wa.size(), act_wb.size(), exp_wb.size());
        end
        foreach (exp_rx[i]) begin
            checks++;
            if (i >= act_rx.size() || act_rx[i] !== exp_rx[i]) begin
                failures++;
                $display("FAIL rand_rx%0d: got %h, required %h", i, (i < act_rx.size()) ? act_rx[i] : 8'hxx, exp_rx[i]);
            end
        end
        foreach (exp_wa[i]) begin
            checks++;
            if (i >= act_wa.size() || act_wa[i] !== exp_wa[i] || i >= act_wb.size() || act_wb[i] !== exp_wb[i]) begin
                failures++;
                $display("FAIL rand_write%0d: required a=%h b=%h", i, exp_wa[i], exp_wb[i]);
            end
        end
        checks++;
        if (ram_a.waddr !== 8'(m_addr_a) || ram_b.waddr !== 2'(m_addr_b) || ferr_a !== m_ferr || wrap_b !== m_wrap_b) begin
            failures++;
            $display("FAIL rand_state: waddr_a=%h waddr_b=%h ferr=%b wrap_b=%b, required %h %h %b %b", ram_a.waddr,
                     ram_b.waddr, ferr_a, wrap_b, 8'(m_addr_a), 2'(m_addr_b), m_ferr, m_wrap_b);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        apply_reset();
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (perr_a !== 1'b1 || act_rx.size() != 0) begin
            failures++;
            $display("FAIL parity_bad: perr=%b rx=%0d, required 1 0", perr_a, act_rx.size());
        end
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (act_rx.size() != 1 || act_rx[0] !== 8'h03) begin
            failures++;
            $display("FAIL parity_good: %0d bytes, required one 03", act_rx.size());
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
